reg_file_ctrl: RTL
==================

Name: reg_file_ctrl

Overview:
- Initiator side of the register-file access interface.
- Parses command frames from the UART receive byte stream and issues single-cycle write or read strobes to the register file.
- Captures read data and hands it to the UART transmitter.
- Sits between UART RX/TX and the register file in the system top level.

Parameters:
- DATA_WIDTH, 8, byte/register width.
- REG_FILE_DEPTH, 16, number of addressable registers.
- ADDR_WIDTH, $clog2(REG_FILE_DEPTH), register address width.
- WR_CMD, 8'hAA, write-frame opcode.
- RD_CMD, 8'hBB, read-frame opcode.
- RD_TIMEOUT, 8, max cycles to wait for RdData_valid after RdEn.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_valid  in  1  read data valid strobe.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle transmit request.
- TX_Busy  in  1  transmitter busy; no request accepted while high.
- Cmd_Err  out  1  one-cycle error pulse.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; internal latches and counter cleared. RST asserted in any state aborts the frame; no strobe is issued on the following cycle.
- Frames:
  - Write: WR_CMD, addr, data.
  - Read: RD_CMD, addr.
  - Bytes are consumed only on cycles with RX_D_VLD=1; there is no inter-byte timeout.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - WR_CMD -> WR_ADDR.
  - RD_CMD -> RD_ADDR.
  - Any other byte -> Cmd_Err pulse next cycle; stay IDLE.
- WR_ADDR / RD_ADDR, on RX_D_VLD:
  - Byte >= REG_FILE_DEPTH -> Cmd_Err pulse, IDLE.
  - Otherwise latch byte[ADDR_WIDTH-1:0].
  - WR_ADDR -> WR_DATA.
  - RD_ADDR -> drive Address, pulse RdEn for exactly 1 cycle (registered, cycle after the byte), -> RD_WAIT.
- WR_DATA, on RX_D_VLD: registered outputs next cycle: Address=latched addr, WrData=byte, WrEn=1 for exactly 1 cycle; -> IDLE.
- RD_WAIT: count cycles from the RdEn cycle.
  - RdData_valid=1 -> latch RdData, -> TX_SEND.
  - Count reaches RD_TIMEOUT with no valid -> Cmd_Err pulse, IDLE.
- TX_SEND:
  - While TX_Busy=1: hold.
  - First cycle TX_Busy=0: TX_P_DATA=latched data, TX_D_VLD=1 for 1 cycle; -> IDLE.
  - TX_P_DATA holds its value until the next read.
- WrEn and RdEn are never high in the same cycle; each strobe is exactly 1 cycle wide.
- Address and WrData hold their last values after a strobe.
- RX_D_VLD while in RD_WAIT or TX_SEND: byte dropped, Cmd_Err pulse, current operation continues.
- Write latency: WrEn asserted 1 cycle after the data byte strobe.
- Read latency: RdEn asserted 1 cycle after the addr byte strobe; TX_D_VLD asserted at earliest 1 cycle after RdData_valid.
- Cmd_Err: registered, 1 cycle, never held.

Decomposition:
- Shared package sys_ctrl_pkg:
  - state enum (6 states).
  - WR_CMD and RD_CMD opcode constants, reused by the future ALU command controller.
- One natural sub-module, reg_ctrl_timeout_cnt: a loadable down-counter with an expire flag for RD_WAIT.
- FSM and datapath registers remain in reg_file_ctrl.

Test Plan:
- Write: RX bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=8'h3C, 1 cycle after the 3C strobe; RdEn stays 0; Busy returns 0.
- Read: BB,02 with reg-file model returning 8'h81 one cycle after RdEn -> one RdEn pulse with Address=2; then TX_D_VLD pulse with TX_P_DATA=8'h81.
- Backpressure: read of addr 3 returning 8'h20 with TX_Busy held high 10 cycles -> no TX_D_VLD until TX_Busy falls; exactly 1 pulse with 8'h20 on the first low cycle.
- Errors:
  - Opcode 8'h55 -> Cmd_Err pulse, no strobes.
  - AA,12 (addr >= 16) -> Cmd_Err, no WrEn.
  - BB,01 with RdData_valid never asserted -> Cmd_Err after 8 cycles, no TX_D_VLD.
- Reset mid-frame: AA,07, then RST for 1 cycle, then 9F -> no WrEn; Cmd_Err pulse (9F seen as opcode in IDLE); all outputs 0 during reset.
- Back-to-back: AA,00,11 immediately followed by BB,00 -> WrEn then RdEn on different cycles; TX_P_DATA=8'h11.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// ============================================================================
// Module   : sys_ctrl_pkg
// Brief    : Shared controller state encoding and command opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_ctrl_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_file_ctrl_if.sv
// ============================================================================
// Module   : reg_file_ctrl_if
// Brief    : UART byte streams and register-file strobes seen by the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_ctrl_if
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_valid;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_Busy;
  logic                  Cmd_Err;
  logic                  Busy;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err, Busy
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err, Busy
  );

endinterface

`default_nettype wire

// File: rtl/reg_ctrl_timeout_cnt.sv
// ============================================================================
// Module   : reg_ctrl_timeout_cnt
// Brief    : Loadable down-counter; expire flag is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_ctrl_timeout_cnt #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  output logic                  o_expired
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reg_file_ctrl.sv
// ============================================================================
// Module   : reg_file_ctrl
// Brief    : Parses UART command frames into register-file strobes and returns
//            read data to the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 8,
  parameter int                   REG_FILE_DEPTH = 16,
  parameter int                   ADDR_WIDTH     = $clog2(REG_FILE_DEPTH),
  parameter logic [DATA_WIDTH-1:0] WR_CMD        = DATA_WIDTH'(sys_ctrl_pkg::WR_CMD),
  parameter logic [DATA_WIDTH-1:0] RD_CMD        = DATA_WIDTH'(sys_ctrl_pkg::RD_CMD),
  parameter int                   RD_TIMEOUT     = 8
) (
  input wire logic        CLK,
  input wire logic        RST,
  reg_file_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  busy_q, busy_d;
  logic                  cnt_load;
  logic                  cnt_expired;
  logic                  addr_ok;

  // Loaded so that it reaches zero on the RD_TIMEOUT-th cycle counted from the RdEn cycle.
  reg_ctrl_timeout_cnt #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (cnt_load),
    .i_load_val (CNT_W'(RD_TIMEOUT - 1)),
    .i_en       (state_q == RD_WAIT),
    .o_expired  (cnt_expired)
  );

  assign addr_ok = (32'(bus.RX_P_DATA) < 32'(REG_FILE_DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_lat_d = addr_lat_q;
    address_d  = address_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_vld_d   = 1'b0;
    cmd_err_d  = 1'b0;
    cnt_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WR_CMD) begin
            state_d = WR_ADDR;
          end else if (bus.RX_P_DATA == RD_CMD) begin
            state_d = RD_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          if (addr_ok) begin
            addr_lat_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state_d    = WR_DATA;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          address_d = addr_lat_q;
          wr_data_d = bus.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          if (addr_ok) begin
            addr_lat_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            address_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d    = 1'b1;
            cnt_load   = 1'b1;
            state_d    = RD_WAIT;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      RD_WAIT: begin
        // Stray bytes mid-read are flagged and dropped; the read carries on.
        cmd_err_d = bus.RX_D_VLD;
        if (bus.RdData_valid) begin
          rd_data_d = bus.RdData;
          state_d   = TX_SEND;
        end else if (cnt_expired) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_SEND: begin
        cmd_err_d = bus.RX_D_VLD;
        if (!bus.TX_Busy) begin
          tx_data_d = rd_data_q;
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_lat_q <= '0;
      address_q  <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lat_q <= addr_lat_d;
      address_q  <= address_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_vld_q   <= tx_vld_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.Address   = address_q;
  assign bus.WrData    = wr_data_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.Cmd_Err   = cmd_err_q;
  assign bus.Busy      = busy_q;

endmodule

`default_nettype wire
